// File: rtl/capture_sequencer_if.sv
// -----------------------------------------------------------------------------
// capture_sequencer_if
// Stream bundle for the capture sequencer: the trigger-block input stream
// (sti_*) and the sample-memory-writer output stream (sto_*).
//   sti_tready  sequencer -> source  input stream ready
//   sti_tvalid  source -> sequencer  input stream valid
//   sti_tevent  source -> sequencer  event flags, bit 0 trigger, bit 1 abort
//   sti_tdata   source -> sequencer  input sample
//   sto_tready  writer -> sequencer  output stream ready
//   sto_tvalid  sequencer -> writer  output stream valid
//   sto_ttrig   sequencer -> writer  marks the trigger sample
//   sto_tlast   sequencer -> writer  marks the final sample of a capture
//   sto_tdata   sequencer -> writer  output sample
// Modport slave is the sequencer side, master is the environment side.
// -----------------------------------------------------------------------------
interface capture_sequencer_if #(
  parameter int SEW = 2,
  parameter int SDW = 32
);
  logic           sti_tready;
  logic           sti_tvalid;
  logic [SEW-1:0] sti_tevent;
  logic [SDW-1:0] sti_tdata;
  logic           sto_tready;
  logic           sto_tvalid;
  logic           sto_ttrig;
  logic           sto_tlast;
  logic [SDW-1:0] sto_tdata;

  modport slave (
    output sti_tready,
    input  sti_tvalid, sti_tevent, sti_tdata,
    input  sto_tready,
    output sto_tvalid, sto_ttrig, sto_tlast, sto_tdata
  );

  modport master (
    input  sti_tready,
    output sti_tvalid, sti_tevent, sti_tdata,
    output sto_tready,
    input  sto_tvalid, sto_ttrig, sto_tlast, sto_tdata
  );
endinterface

// File: rtl/capture_sequencer.sv
// -----------------------------------------------------------------------------
// capture_sequencer
// Sequences one acquisition: arm, collect cfg_pre pre-trigger samples, wait for
// a trigger, forward cfg_post post-trigger samples, stop. Forwarded samples go
// out through a single output register with trigger/last markers.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ctl_arm, ctl_abort  single-cycle host pulses
//   cfg_pre, cfg_post   pre-/post-trigger sample counts, sampled at arm
//   cfg_timeout         (CAPTURE_SEQ_TIMEOUT_EN only) forced-trigger count in
//                       WAIT, 0 disables
//   stm                 input/output streams (capture_sequencer_if.slave)
//   sts_busy/done/abort/state  host status
// Optional feature macro: CAPTURE_SEQ_TIMEOUT_EN
// -----------------------------------------------------------------------------
module capture_sequencer #(
  parameter int SEW = 2,
  parameter int SDW = 32,
  parameter int CCW = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ctl_arm,
  input  logic           ctl_abort,
`ifdef CAPTURE_SEQ_TIMEOUT_EN
  input  logic [CCW-1:0] cfg_timeout,
`endif
  input  logic [CCW-1:0] cfg_pre,
  input  logic [CCW-1:0] cfg_post,
  capture_sequencer_if.slave stm,
  output logic           sts_busy,
  output logic           sts_done,
  output logic           sts_abort,
  output logic [2:0]     sts_state
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_POST = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  localparam logic [CCW-1:0] CNT_ZERO = {CCW{1'b0}};
  localparam logic [CCW-1:0] CNT_ONE  = {{(CCW-1){1'b0}}, 1'b1};

  function automatic logic is_busy(input logic [2:0] st);
    return (st == ST_PRE) || (st == ST_WAIT) || (st == ST_POST);
  endfunction

  logic [2:0]     state_r, state_nxt_s;
  logic [CCW-1:0] pre_cfg_r, post_cfg_r;
  logic [CCW-1:0] pre_cnt_r, pre_cnt_nxt_s, pre_inc_s;
  logic [CCW-1:0] post_cnt_r, post_cnt_nxt_s, post_inc_s;
  logic           busy_s, xfer_s, fwd_s, trig_s, last_s, arm_s, abort_set_s, tmo_hit_s;
  logic           out_valid_r, out_trig_r, out_last_r;
  logic [SDW-1:0] out_data_r;
  logic           busy_r, done_r, abort_r;

`ifdef CAPTURE_SEQ_TIMEOUT_EN
  logic [CCW-1:0] tmo_cfg_r, wait_cnt_r, wait_cnt_nxt_s, wait_inc_s;
  assign wait_inc_s = wait_cnt_r + CNT_ONE;
  assign tmo_hit_s  = (tmo_cfg_r != CNT_ZERO) && (wait_inc_s == tmo_cfg_r);
`else
  assign tmo_hit_s  = 1'b0;
`endif

  // While capturing, the single output register gates input acceptance.
  assign busy_s         = is_busy(state_r);
  assign stm.sti_tready = busy_s ? (stm.sto_tready | ~out_valid_r) : 1'b1;
  assign xfer_s         = stm.sti_tvalid & stm.sti_tready;
  assign pre_inc_s      = pre_cnt_r + CNT_ONE;
  assign post_inc_s     = post_cnt_r + CNT_ONE;

  // Next-state, counter and forwarding decision for the current cycle.
  always_comb begin
    state_nxt_s    = state_r;
    pre_cnt_nxt_s  = pre_cnt_r;
    post_cnt_nxt_s = post_cnt_r;
`ifdef CAPTURE_SEQ_TIMEOUT_EN
    wait_cnt_nxt_s = wait_cnt_r;
`endif
    fwd_s       = 1'b0;
    trig_s      = 1'b0;
    last_s      = 1'b0;
    arm_s       = 1'b0;
    abort_set_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        // An abort pulse alongside arm suppresses the arm.
        if (ctl_arm && !ctl_abort) begin
          arm_s          = 1'b1;
          pre_cnt_nxt_s  = CNT_ZERO;
          post_cnt_nxt_s = CNT_ZERO;
`ifdef CAPTURE_SEQ_TIMEOUT_EN
          wait_cnt_nxt_s = CNT_ZERO;
`endif
          state_nxt_s    = (cfg_pre == CNT_ZERO) ? ST_WAIT : ST_PRE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_PRE, ST_WAIT, ST_POST: begin
        if (ctl_abort) begin
          // Host abort: stop forwarding at once, no tlast is produced.
          state_nxt_s = ST_DONE;
          abort_set_s = 1'b1;
        end else if (xfer_s) begin
          fwd_s = 1'b1;
          if (stm.sti_tevent[1]) begin
            // In-band abort outranks a trigger on the same sample.
            last_s      = 1'b1;
            abort_set_s = 1'b1;
            state_nxt_s = ST_DONE;
          end else begin
            case (state_r)
              ST_PRE: begin
                pre_cnt_nxt_s = pre_inc_s;
                if (pre_inc_s == pre_cfg_r) begin
                  state_nxt_s = ST_WAIT;
                end else begin
                  state_nxt_s = ST_PRE;
                end
              end
              ST_WAIT: begin
`ifdef CAPTURE_SEQ_TIMEOUT_EN
                wait_cnt_nxt_s = wait_inc_s;
`endif
                if (stm.sti_tevent[0] || tmo_hit_s) begin
                  trig_s         = 1'b1;
                  post_cnt_nxt_s = CNT_ZERO;
                  if (post_cfg_r == CNT_ZERO) begin
                    last_s      = 1'b1;
                    state_nxt_s = ST_DONE;
                  end else begin
                    state_nxt_s = ST_POST;
                  end
                end else begin
                  state_nxt_s = ST_WAIT;
                end
              end
              ST_POST: begin
                post_cnt_nxt_s = post_inc_s;
                if (post_inc_s == post_cfg_r) begin
                  last_s      = 1'b1;
                  state_nxt_s = ST_DONE;
                end else begin
                  state_nxt_s = ST_POST;
                end
              end
              default: state_nxt_s = ST_IDLE;
            endcase
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, counters and the configuration snapshot taken at arm.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      pre_cnt_r  <= CNT_ZERO;
      post_cnt_r <= CNT_ZERO;
      pre_cfg_r  <= CNT_ZERO;
      post_cfg_r <= CNT_ZERO;
`ifdef CAPTURE_SEQ_TIMEOUT_EN
      wait_cnt_r <= CNT_ZERO;
      tmo_cfg_r  <= CNT_ZERO;
`endif
    end else begin
      state_r    <= state_nxt_s;
      pre_cnt_r  <= pre_cnt_nxt_s;
      post_cnt_r <= post_cnt_nxt_s;
`ifdef CAPTURE_SEQ_TIMEOUT_EN
      wait_cnt_r <= wait_cnt_nxt_s;
`endif
      if (arm_s) begin
        pre_cfg_r  <= cfg_pre;
        post_cfg_r <= cfg_post;
`ifdef CAPTURE_SEQ_TIMEOUT_EN
        tmo_cfg_r  <= cfg_timeout;
`endif
      end
    end
  end

  // Output register: loads a forwarded sample, holds it until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_trig_r  <= 1'b0;
      out_last_r  <= 1'b0;
      out_data_r  <= {SDW{1'b0}};
    end else if (fwd_s) begin
      out_valid_r <= 1'b1;
      out_trig_r  <= trig_s;
      out_last_r  <= last_s;
      out_data_r  <= stm.sti_tdata;
    end else if (stm.sto_tready) begin
      out_valid_r <= 1'b0;
    end
  end

  // Host status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      abort_r <= 1'b0;
    end else begin
      busy_r <= is_busy(state_nxt_s);
      done_r <= (state_nxt_s == ST_DONE);
      if (arm_s) begin
        abort_r <= 1'b0;
      end else if (abort_set_s) begin
        abort_r <= 1'b1;
      end
    end
  end

  assign stm.sto_tvalid = out_valid_r;
  assign stm.sto_ttrig  = out_trig_r;
  assign stm.sto_tlast  = out_last_r;
  assign stm.sto_tdata  = out_data_r;
  assign sts_busy       = busy_r;
  assign sts_done       = done_r;
  assign sts_abort      = abort_r;
  assign sts_state      = state_r;

endmodule

// File: tb/tb_capture_sequencer.sv
// -----------------------------------------------------------------------------
// tb_capture_sequencer
// Directed bench for capture_sequencer. Inputs change 1 time unit after the
// rising edge; outputs and accepted output beats are observed on the falling
// edge. Define CAPTURE_SEQ_TIMEOUT_EN to also cover the WAIT timeout.
// -----------------------------------------------------------------------------
module tb_capture_sequencer;
  localparam int SEW = 2;
  localparam int SDW = 32;
  localparam int CCW = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           ctl_arm = 1'b0;
  logic           ctl_abort = 1'b0;
  logic [CCW-1:0] cfg_pre = '0;
  logic [CCW-1:0] cfg_post = '0;
`ifdef CAPTURE_SEQ_TIMEOUT_EN
  logic [CCW-1:0] cfg_timeout = '0;
`endif
  logic           sts_busy, sts_done, sts_abort;
  logic [2:0]     sts_state;

  int errors = 0;
  int checks = 0;
  logic [SDW+1:0] mon_q[$];   // {data, trig, last} of each accepted output beat

  capture_sequencer_if #(.SEW(SEW), .SDW(SDW)) bus ();

  capture_sequencer #(.SEW(SEW), .SDW(SDW), .CCW(CCW)) dut (
    .clk         (clk),
    .rst         (rst),
    .ctl_arm     (ctl_arm),
    .ctl_abort   (ctl_abort),
`ifdef CAPTURE_SEQ_TIMEOUT_EN
    .cfg_timeout (cfg_timeout),
`endif
    .cfg_pre     (cfg_pre),
    .cfg_post    (cfg_post),
    .stm         (bus),
    .sts_busy    (sts_busy),
    .sts_done    (sts_done),
    .sts_abort   (sts_abort),
    .sts_state   (sts_state)
  );

  always #5 clk = ~clk;

  // Record every output beat that will be accepted on the coming rising edge.
  always @(negedge clk) begin
    if (!rst && bus.sto_tvalid && bus.sto_tready)
      mon_q.push_back({bus.sto_tdata, bus.sto_ttrig, bus.sto_tlast});
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.sti_tvalid = 1'b0;
    repeat (n) step();
  endtask

  task automatic send(input logic [SDW-1:0] d, input logic [SEW-1:0] ev);
    int k;
    bus.sti_tvalid = 1'b1;
    bus.sti_tdata  = d;
    bus.sti_tevent = ev;
    k = 0;
    while (k < 50) begin
      @(negedge clk);
      if (bus.sti_tready) break;
      k++;
    end
    checks++;
    if (k == 50) begin
      errors++;
      $display("FAIL send_tready: data %h, sti_tready still 0 after 50 cycles, need 1", d);
    end
    @(posedge clk);
    #1;
    bus.sti_tvalid = 1'b0;
  endtask

  task automatic arm(input int pre, input int post, input int tmo);
    cfg_pre  = CCW'(pre);
    cfg_post = CCW'(post);
`ifdef CAPTURE_SEQ_TIMEOUT_EN
    cfg_timeout = CCW'(tmo);
`else
    if (tmo != 0) $display("note: timeout %0d ignored in this build", tmo);
`endif
    mon_q.delete();
    ctl_arm = 1'b1;
    step();
    ctl_arm = 1'b0;
  endtask

  task automatic test_reset();
    logic [41:0] got;
    logic [41:0] exp;
    rst = 1'b1;
    repeat (3) step();
    @(negedge clk);
    got = {bus.sto_tvalid, bus.sto_ttrig, bus.sto_tlast, bus.sto_tdata,
           sts_busy, sts_done, sts_abort, sts_state, bus.sti_tready};
    exp = {1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_values: got %h need %h", got, exp);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [SDW+1:0] exp;
    idle(2);
    arm(3, 2, 0);
    for (int i = 1; i <= 10; i++) send(SDW'(i), (i == 2 || i == 6) ? 2'b01 : 2'b00);
    idle(4);
    checks++;
    if (mon_q.size() !== 8) begin
      errors++;
      $display("FAIL basic_count: got %0d beats need 8", mon_q.size());
    end
    for (int i = 0; i < 8; i++) begin
      exp = {SDW'(i + 1), (i == 5), (i == 7)};
      checks++;
      if (i >= mon_q.size()) begin
        errors++;
        $display("FAIL basic_beat%0d: missing, need %h", i, exp);
      end else if (mon_q[i] !== exp) begin
        errors++;
        $display("FAIL basic_beat%0d: got %h need %h", i, mon_q[i], exp);
      end
    end
    checks++;
    if ({sts_busy, sts_done, sts_abort, sts_state} !== {1'b0, 1'b1, 1'b0, 3'd4}) begin
      errors++;
      $display("FAIL basic_status: got busy/done/abort/state %b need 0104",
               {sts_busy, sts_done, sts_abort, sts_state});
    end
  endtask

  task automatic test_zero_counts();
    idle(2);
    arm(0, 0, 0);
    @(negedge clk);
    checks++;
    if ({sts_done, sts_abort, sts_state} !== {1'b0, 1'b0, 3'd2}) begin
      errors++;
      $display("FAIL zero_arm_state: got done/abort/state %b need 00010",
               {sts_done, sts_abort, sts_state});
    end
    step();
    send(32'h55, 2'b01);
    send(32'h56, 2'b01);
    idle(3);
    checks++;
    if (mon_q.size() !== 1 || mon_q[0] !== {32'h55, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL zero_beat: got %0d beats first %h need 1 beat %h",
               mon_q.size(), (mon_q.size() > 0) ? mon_q[0] : '0, {32'h55, 1'b1, 1'b1});
    end
    checks++;
    if ({sts_done, sts_state} !== {1'b1, 3'd4}) begin
      errors++;
      $display("FAIL zero_done: got done/state %b need 1100", {sts_done, sts_state});
    end
  endtask

  task automatic test_backpressure();
    logic [SDW+1:0] exp;
    idle(2);
    arm(1, 4, 0);
    // A second arm while capturing, with different config, must be ignored.
    cfg_pre = '0;
    ctl_arm = 1'b1;
    step();
    ctl_arm = 1'b0;
    @(negedge clk);
    checks++;
    if (sts_state !== 3'd1) begin
      errors++;
      $display("FAIL busy_arm_ignored: got state %0d need 1", sts_state);
    end
    step();
    send(32'h10, 2'b00);
    send(32'h11, 2'b01);
    send(32'h12, 2'b00);
    bus.sto_tready = 1'b0;
    bus.sti_tvalid = 1'b1;
    bus.sti_tdata  = 32'h13;
    bus.sti_tevent = 2'b00;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.sti_tready, bus.sto_tvalid, bus.sto_tdata} !== {1'b0, 1'b1, 32'h12}) begin
        errors++;
        $display("FAIL stall_hold%0d: got tready/tvalid/tdata %b/%b/%h need 0/1/00000012",
                 c, bus.sti_tready, bus.sto_tvalid, bus.sto_tdata);
      end
    end
    @(posedge clk);
    #1;
    bus.sto_tready = 1'b1;
    send(32'h13, 2'b00);
    send(32'h14, 2'b00);
    send(32'h15, 2'b00);
    send(32'h16, 2'b00);
    idle(3);
    checks++;
    if (mon_q.size() !== 6) begin
      errors++;
      $display("FAIL stall_count: got %0d beats need 6", mon_q.size());
    end
    for (int i = 0; i < 6; i++) begin
      exp = {SDW'(32'h10 + i), (i == 1), (i == 5)};
      checks++;
      if (i >= mon_q.size()) begin
        errors++;
        $display("FAIL stall_beat%0d: missing, need %h", i, exp);
      end else if (mon_q[i] !== exp) begin
        errors++;
        $display("FAIL stall_beat%0d: got %h need %h", i, mon_q[i], exp);
      end
    end
  endtask

  task automatic test_ctl_abort();
    idle(2);
    arm(1, 2, 0);
    send(32'h20, 2'b00);
    send(32'h21, 2'b00);
    bus.sto_tready = 1'b0;
    ctl_abort = 1'b1;
    step();
    ctl_abort = 1'b0;
    @(negedge clk);
    checks++;
    if ({sts_done, sts_abort, sts_state, bus.sto_tvalid, bus.sto_tlast, bus.sto_tdata} !==
        {1'b1, 1'b1, 3'd4, 1'b1, 1'b0, 32'h21}) begin
      errors++;
      $display("FAIL ctl_abort_hold: got done/abort/state %b tvalid %b tlast %b tdata %h need 11100 1 0 00000021",
               {sts_done, sts_abort, sts_state}, bus.sto_tvalid, bus.sto_tlast, bus.sto_tdata);
    end
    step();
    bus.sto_tready = 1'b1;
    send(32'h22, 2'b01);
    send(32'h23, 2'b00);
    idle(3);
    checks++;
    if (mon_q.size() !== 2 || mon_q[0] !== {32'h20, 1'b0, 1'b0} || mon_q[1] !== {32'h21, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL ctl_abort_beats: got %0d beats last %h need 2 beats ending %h",
               mon_q.size(), (mon_q.size() > 0) ? mon_q[$] : '0, {32'h21, 1'b0, 1'b0});
    end
  endtask

  task automatic test_event_abort();
    idle(2);
    arm(0, 3, 0);
    @(negedge clk);
    checks++;
    if ({sts_abort, sts_state} !== {1'b0, 3'd2}) begin
      errors++;
      $display("FAIL rearm_clears_abort: got abort/state %b need 0010", {sts_abort, sts_state});
    end
    step();
    send(32'h9, 2'b00);
    send(32'hA, 2'b11);
    send(32'hB, 2'b01);
    idle(3);
    checks++;
    if (mon_q.size() !== 2 || mon_q[0] !== {32'h9, 1'b0, 1'b0} || mon_q[1] !== {32'hA, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL event_abort_beats: got %0d beats last %h need 2 beats ending %h",
               mon_q.size(), (mon_q.size() > 0) ? mon_q[$] : '0, {32'hA, 1'b0, 1'b1});
    end
    checks++;
    if ({sts_busy, sts_done, sts_abort, sts_state} !== {1'b0, 1'b1, 1'b1, 3'd4}) begin
      errors++;
      $display("FAIL event_abort_status: got busy/done/abort/state %b need 011100",
               {sts_busy, sts_done, sts_abort, sts_state});
    end
    // Arm together with abort: the arm is suppressed, DONE and abort persist.
    cfg_pre   = 16'd2;
    ctl_arm   = 1'b1;
    ctl_abort = 1'b1;
    step();
    ctl_arm   = 1'b0;
    ctl_abort = 1'b0;
    @(negedge clk);
    checks++;
    if ({sts_done, sts_abort, sts_state} !== {1'b1, 1'b1, 3'd4}) begin
      errors++;
      $display("FAIL arm_with_abort: got done/abort/state %b need 11100",
               {sts_done, sts_abort, sts_state});
    end
    step();
  endtask

`ifdef CAPTURE_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    logic [SDW+1:0] exp;
    idle(2);
    arm(0, 1, 4);
    for (int i = 1; i <= 6; i++) send(SDW'(i), 2'b00);
    idle(3);
    checks++;
    if (mon_q.size() !== 5) begin
      errors++;
      $display("FAIL timeout_count: got %0d beats need 5", mon_q.size());
    end
    for (int i = 0; i < 5; i++) begin
      exp = {SDW'(i + 1), (i == 3), (i == 4)};
      checks++;
      if (i >= mon_q.size()) begin
        errors++;
        $display("FAIL timeout_beat%0d: missing, need %h", i, exp);
      end else if (mon_q[i] !== exp) begin
        errors++;
        $display("FAIL timeout_beat%0d: got %h need %h", i, mon_q[i], exp);
      end
    end
  endtask
`endif

  initial begin
    bus.sti_tvalid = 1'b0;
    bus.sti_tevent = '0;
    bus.sti_tdata  = '0;
    bus.sto_tready = 1'b1;
    test_reset();
    test_basic();
    test_zero_counts();
    test_backpressure();
    test_ctl_abort();
    test_event_abort();
`ifdef CAPTURE_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/capture_sequencer.md
# capture_sequencer

Capture controller that sits directly downstream of the trigger block's output stream and sequences one acquisition.
- Flow: arm → collect a minimum pre-trigger sample count → wait for the trigger event → forward a fixed post-trigger sample count → stop.
- Forwards the selected samples to the sample-memory writer with trigger and last markers.
- Exposes arm/abort controls and status to the host register file.

## Interface
Parameters:
- SEW, 2, sample event width; bit 0 = trigger, bit 1 = abort
- SDW, 32, sample data width
- CCW, 16, capture counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- ctl_arm  in  1  single-cycle pulse; starts a capture
- ctl_abort  in  1  single-cycle pulse; terminates a capture
- cfg_pre  in  CCW  minimum pre-trigger samples
- cfg_post  in  CCW  post-trigger samples following the trigger sample
- sti_tready  out  1  input stream ready
- sti_tvalid  in  1  input stream valid
- sti_tevent  in  SEW  input event flags
- sti_tdata  in  SDW  input sample
- sto_tready  in  1  output stream ready
- sto_tvalid  out  1  output stream valid
- sto_ttrig  out  1  marks the trigger sample
- sto_tlast  out  1  marks the final sample of a capture
- sto_tdata  out  SDW  output sample
- sts_busy  out  1  state is PRE, WAIT or POST
- sts_done  out  1  capture finished
- sts_abort  out  1  capture ended by abort
- sts_state  out  3  current state encoding

## Operation
States, with encoding on sts_state:
- IDLE = 0
- PRE = 1
- WAIT = 2
- POST = 3
- DONE = 4

Per-state behaviour:
- **IDLE/DONE:** sti_tready=1; samples are consumed and dropped. ctl_arm clears sts_done/sts_abort, loads the counters, and moves to PRE. If cfg_pre=0 it moves straight to WAIT.
- **PRE:** every input transfer is forwarded. Trigger flags are ignored. The pre counter increments per transfer; the cfg_pre-th transfer moves to WAIT.
- **WAIT:** transfers are forwarded. A transfer with sti_tevent[0]=1 is forwarded with sto_ttrig=1, and the state moves to POST with the post counter cleared. If cfg_post=0, that same sample also carries sto_tlast=1 and the state moves to DONE.
- **POST:** transfers are forwarded. The cfg_post-th transfer after the trigger carries sto_tlast=1, and the state moves to DONE. Trigger flags are ignored.

Abort handling:
- A transfer with sti_tevent[1]=1 in PRE/WAIT/POST is forwarded with sto_tlast=1. The state moves to DONE with sts_abort=1. An abort flag wins over a trigger flag on the same sample.
- ctl_abort in PRE/WAIT/POST moves to DONE with sts_abort=1. No further samples are forwarded and no tlast is generated. A sample already held in the output register is still delivered unchanged.

Control conflicts:
- ctl_arm outside IDLE/DONE is ignored.
- ctl_arm together with ctl_abort: abort wins.
- ctl_abort in IDLE/DONE: no effect.

Counters and status:
- Counters are CCW bits and compare for equality, so they never wrap.
- cfg_pre/cfg_post are sampled at arm; changes mid-capture have no effect.
- sts_done=1 in DONE; it is cleared by arm or rst.

## Timing
- Output stage is one register. sti_tready = sto_tready | ~sto_tvalid in PRE/WAIT/POST.
- Latency is 1 cycle from input transfer to sto_tvalid. sto_tdata/ttrig/tlast are stable while sto_tvalid=1 and sto_tready=0.
- State transitions take effect on the clock edge of the causing transfer or pulse. The next cycle's input is evaluated in the new state.
- Full throughput: one sample per cycle when sto_tready=1.
- Reset values:
  - sto_tvalid=0, sto_ttrig=0, sto_tlast=0, sto_tdata=0
  - sts_busy=0, sts_done=0, sts_abort=0, sts_state=IDLE
  - sti_tready=1
- rst mid-capture discards any held sample with no tlast.

## Configuration
- CAPTURE_SEQ_TIMEOUT_EN, when defined:
  - Adds input port cfg_timeout [CCW].
  - In WAIT, counts forwarded samples. On the cfg_timeout-th sample without a trigger, that sample is treated as the trigger: sto_ttrig=1, state moves to POST.
  - cfg_timeout=0 disables the timeout.
- Without it: the port is absent and WAIT lasts until a trigger, an abort flag or ctl_abort.

## Test plan
- cfg_pre=3, cfg_post=2, arm, stream data 1..10 with tevent[0] on data 2 and data 6 → forwarded 1..8; ttrig on 6 only; tlast on 8; DONE, sts_done=1.
- cfg_pre=0, cfg_post=0, arm, trigger on the first sample (data 0x55) → single output 0x55 with ttrig=1, tlast=1.
- Arm, trigger, then hold sto_tready=0 for 5 cycles mid-POST → sti_tready=0, no sample lost or duplicated, output data held stable.
- ctl_abort in WAIT while an output sample is pending → pending sample delivered with tlast=0; sts_abort=1, sts_done=1; later inputs dropped.
- tevent=2'b11 in WAIT on data 0xA → 0xA forwarded with tlast=1, ttrig=0; sts_abort=1.
- With CAPTURE_SEQ_TIMEOUT_EN, cfg_pre=0, cfg_timeout=4, cfg_post=1, no trigger flags → ttrig on the 4th sample, tlast on the 5th.
